// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the combinational 4-bit alu and its upstream
// sequencer alu_seq_ctrl: op-code constants, the sequencer FSM state
// encoding and the default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// alu
// Purely combinational ALU driven by alu_seq_ctrl.
// Ports:
//   A, B  : operands (WIDTH bits)
//   OP    : 00 ADD, 01 SUB, 10 AND, 11 OR
//   R     : result, wraps modulo 2^WIDTH
//   CF    : carry out for ADD, borrow for SUB, 0 for logic ops
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] R,
  output logic             CF
);

  // One extra bit so the carry/borrow falls out of the same adder.
  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    R   = '0;
    CF  = 1'b0;
    case (OP)
      OP_ADD: begin
        ext = {1'b0, A} + {1'b0, B};
        R   = ext[WIDTH-1:0];
        CF  = ext[WIDTH];
      end
      OP_SUB: begin
        ext = {1'b0, A} - {1'b0, B};
        R   = ext[WIDTH-1:0];
        CF  = ext[WIDTH];
      end
      OP_AND: R = A & B;
      OP_OR:  R = A | B;
      default: R = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Accumulator sequencer sitting upstream of the combinational alu. Accepts
// one command per valid/ready handshake, either loading the accumulator
// directly or running one ALU operation cmd_rpt+1 times with the result
// fed back into the accumulator each cycle.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_load            : 1 = load accumulator with cmd_operand, no ALU pass
//   cmd_op              : ALU op code for the command
//   cmd_operand         : B operand or load value
//   cmd_rpt             : repeat count minus one
//   alu_a/alu_b/alu_op  : drive alu.A / alu.B / alu.OP (acc, operand, op)
//   alu_r/alu_cf        : alu.R / alu.CF, sampled only in EXEC
//   acc, cf             : accumulator and carry of the last write-back
//   done                : one-cycle pulse when a command completes
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RPT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [RPT_W-1:0] cmd_rpt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cf,
  output logic [WIDTH-1:0] acc,
  output logic             cf,
  output logic             done
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cf_q, cf_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cf_q      <= 1'b0;
      op_q      <= OP_ADD;
      operand_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cf_q      <= cf_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cf_d      = cf_q;
    op_d      = op_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          operand_d = cmd_operand;
          cnt_d     = cmd_rpt;
          if (cmd_load) begin
            acc_d   = cmd_operand;
            cf_d    = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // Every EXEC cycle writes back, so cf ends up holding only the
        // carry of the final iteration.
        acc_d = alu_r;
        cf_d  = alu_cf;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - RPT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs are decoded from registers, so the alu feedback path
  // (alu_a -> alu -> alu_r -> acc_q) is broken by the accumulator flop.
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign alu_a     = acc_q;
  assign alu_b     = operand_q;
  assign alu_op    = op_q;
  assign acc       = acc_q;
  assign cf        = cf_q;

endmodule
